controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
Moore FSM that sequences a multi-cycle MIPS-32 datapath. It replaces the single-cycle opcode decoder. It drives register enables (PC, IR, register file, data memory) and the mux selects of the shared ALU, one step per clock. Data memory accesses use a ready handshake so wait-state memories can be attached.

Parameters:
CNT_W, 32, width of the cycle/instruction counters (optional feature only)
MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before trapping; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  data memory has completed the current access
PCWrite  out  1  unconditional PC load
PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
Branch  out  2  01 beq, 10 bne, 00 none; datapath gates PC load with the ALU zero flag
IRWrite  out  1  load instruction register
RegWrite  out  1  register-file write enable
RegDst  out  1  0 rt, 1 rd
MemtoReg  out  1  0 ALU result, 1 memory data
MemRead  out  1  data memory read strobe
MemWrite  out  1  data memory write strobe
ALUSrcA  out  1  0 PC, 1 rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 reserved
trap  out  1  sticky illegal-opcode / memory-timeout flag
state_out  out  4  current state, for debug and bench

Behaviour:
- Outputs are a pure function of the state register (Moore). No combinational path from Opcode or mem_ready to any output.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 15.
- Reset: state goes to IDLE. Every output is 0 and trap is 0. The next cycle after reset is deasserted enters FETCH.
- Reset asserted in any state (including mid-memory-wait or TRAP) wins on that edge. Memory strobes drop the following cycle.
- FETCH: IRWrite=1, PCWrite=1, PCSrc=00, ALUSrcA=0, ALUSrcB=01, ALUOp=00. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed). Next state by Opcode:
  - 000000 goes to EXEC_R.
  - 001000 (addi) goes to EXEC_I.
  - 100011 (lw) and 101011 (sw) go to MEM_ADDR.
  - 000100 and 000101 go to BRANCH.
  - 000010 goes to JUMP.
  - Any other opcode goes to TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to WB_ALU with RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to WB_ALU with RegDst=0.
  - RegDst is held in an internal flag set in EXEC_R/EXEC_I.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst=flag. Goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD / MEM_WR: MemRead / MemWrite held at 1 every cycle until mem_ready is sampled 1.
  - Then MEM_RD goes to WB_MEM and MEM_WR goes to FETCH.
  - With zero-wait memory (mem_ready tied 1), each state lasts exactly 1 cycle.
  - A wait counter increments per cycle with mem_ready=0. When it reaches MEM_TIMEOUT (nonzero), the FSM goes to TRAP. The counter clears on leaving the state.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=01 for opcode 000100 and 10 for 000101. Goes to FETCH.
- JUMP: PCWrite=1, PCSrc=10. Goes to FETCH.
- TRAP: all outputs 0, trap=1. Stays in TRAP until reset.
- CPI: R/addi 4, lw 5, sw 4, beq/bne 3, j 3 (zero-wait memory).
- Opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.

Optional Feature:
CTRL_PERF_COUNTERS_EN: when defined, adds outputs cycle_count[CNT_W-1:0] and instr_count[CNT_W-1:0].
- cycle_count increments every cycle outside IDLE/TRAP.
- instr_count increments on each FETCH→DECODE transition.
- Both clear on reset and wrap modulo 2^CNT_W.
When undefined, neither port nor counters exist and behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; state_out=0 one cycle after, then 1; IRWrite=PCWrite=1 in FETCH.
- Opcode 000000 with mem_ready=1 → states 1,2,3,8,1; RegWrite=1 and RegDst=1 only in state 8; ALUOp=10 in state 3.
- Opcode 100011, mem_ready low 3 cycles then high → MemRead=1 for exactly 4 cycles in state 6, then WB_MEM with MemtoReg=1, RegWrite=1; total 8 cycles back to FETCH.
- Opcode 000101 → BRANCH with Branch=10, ALUOp=01, PCSrc=01; back to FETCH after 3 cycles. Opcode 000010 → PCWrite=1, PCSrc=10.
- Opcode 111111 → TRAP, trap=1, all strobes 0 for 20 cycles; reset pulse returns to IDLE with trap=0.
- With MEM_TIMEOUT=15 and mem_ready stuck 0 on sw → MemWrite high 15 cycles, then TRAP. With CTRL_PERF_COUNTERS_EN defined, instr_count=1 after that sequence.

Source files
------------

// File: rtl/controle_multiciclo_if.sv
// Control bus between the multi-cycle controller (master) and the datapath / data memory (slave).
// Opcode and mem_ready flow into the controller; every enable and mux select flows out.
`timescale 1ns/1ps
interface controle_multiciclo_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic [1:0] Branch;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       trap;
  logic [3:0] state_out;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCSrc, Branch, IRWrite, RegWrite, RegDst, MemtoReg,
           MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, trap, state_out
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCSrc, Branch, IRWrite, RegWrite, RegDst, MemtoReg,
           MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, trap, state_out
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Moore control FSM for a multi-cycle MIPS-32 datapath; all outputs are registered from the next state.
// Define CTRL_PERF_COUNTERS_EN to add the cycle_count / instr_count outputs (width CNT_W).
`timescale 1ns/1ps
module controle_multiciclo #(
`ifdef CTRL_PERF_COUNTERS_EN
  parameter int CNT_W       = 32,
`endif
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  controle_multiciclo_if.master bus
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instr_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] branch;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       trap;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Wide enough to hold MEM_TIMEOUT-1, the largest value the counter ever keeps.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              reg_dst_reg, reg_dst_next;
  logic              bne_reg, bne_next;
  ctrl_t             ctrl_reg;
  logic              timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && ((int'(wait_reg) + 1) >= MEM_TIMEOUT);

  function automatic ctrl_t decode_ctrl(input state_t s, input logic rd_flag, input logic bne_flag);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_src    = 2'b00;
        c.alu_src_b = 2'b01;
      end
      // Branch target is computed speculatively while the opcode is decoded.
      S_DECODE: c.alu_src_b = 2'b11;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: c.mem_read  = 1'b1;
      S_MEM_WR: c.mem_write = 1'b1;
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = rd_flag;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = bne_flag ? 2'b10 : 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    reg_dst_next = reg_dst_reg;
    bne_next     = bne_reg;
    case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        bne_next = (bus.Opcode == OP_BNE);
        case (bus.Opcode)
          OP_RTYPE:       state_next = S_EXEC_R;
          OP_ADDI:        state_next = S_EXEC_I;
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          default:        state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        state_next   = S_WB_ALU;
        reg_dst_next = 1'b1;
      end
      S_EXEC_I: begin
        state_next   = S_WB_ALU;
        reg_dst_next = 1'b0;
      end
      // Opcode is looked at again here so the IR need not stay decoded in a flag.
      S_MEM_ADDR: begin
        if (bus.Opcode == OP_LW)      state_next = S_MEM_RD;
        else if (bus.Opcode == OP_SW) state_next = S_MEM_WR;
        else                          state_next = S_TRAP;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          wait_next  = '0;
          state_next = (state_reg == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timeout_hit) begin
          wait_next  = '0;
          state_next = S_TRAP;
        end else if (MEM_TIMEOUT != 0) begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      wait_reg    <= '0;
      reg_dst_reg <= 1'b0;
      bne_reg     <= 1'b0;
      ctrl_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      reg_dst_reg <= reg_dst_next;
      bne_reg     <= bne_next;
      ctrl_reg    <= decode_ctrl(state_next, reg_dst_next, bne_next);
    end
  end

  assign bus.PCWrite   = ctrl_reg.pc_write;
  assign bus.PCSrc     = ctrl_reg.pc_src;
  assign bus.Branch    = ctrl_reg.branch;
  assign bus.IRWrite   = ctrl_reg.ir_write;
  assign bus.RegWrite  = ctrl_reg.reg_write;
  assign bus.RegDst    = ctrl_reg.reg_dst;
  assign bus.MemtoReg  = ctrl_reg.mem_to_reg;
  assign bus.MemRead   = ctrl_reg.mem_read;
  assign bus.MemWrite  = ctrl_reg.mem_write;
  assign bus.ALUSrcA   = ctrl_reg.alu_src_a;
  assign bus.ALUSrcB   = ctrl_reg.alu_src_b;
  assign bus.ALUOp     = ctrl_reg.alu_op;
  assign bus.trap      = ctrl_reg.trap;
  assign bus.state_out = state_reg;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_count_reg;
  logic [CNT_W-1:0] instr_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
    end else begin
      if (state_reg != S_IDLE && state_reg != S_TRAP)
        cycle_count_reg <= cycle_count_reg + CNT_W'(1);
      if (state_reg == S_FETCH)
        instr_count_reg <= instr_count_reg + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_count_reg;
  assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: builds a per-cycle expected trace from the instruction-level
// behaviour (state walk and per-state outputs), then drives and compares it cycle by cycle.
`timescale 1ns/1ps
module tb_controle_multiciclo;
  localparam int TO = 15;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC_R = 4'd3,
                         ST_EXEC_I = 4'd4, ST_MEM_ADDR = 4'd5, ST_MEM_RD = 4'd6, ST_MEM_WR = 4'd7,
                         ST_WB_ALU = 4'd8, ST_WB_MEM = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11,
                         ST_TRAP = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controle_multiciclo_if bus_if ();

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
  controle_multiciclo #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );
`else
  controle_multiciclo #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );
`endif

  typedef struct {
    bit          rst;
    bit          chk;
    logic [5:0]  op;
    bit          rdy;
    logic [3:0]  st;
    logic [16:0] outs;
    int          tag;
    logic [31:0] ecyc;
    logic [31:0] einst;
  } cyc_t;

  cyc_t        trace[$];
  int          cur_tag;
  logic [31:0] m_cyc, m_inst;
  int          n_total, n_pass;
  int          obs_mr[16], obs_mw[16], obs_tr[16], obs_nf[16];
  logic [31:0] obs_ic;

  // Packing: {PCWrite, PCSrc, Branch, IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite,
  //           ALUSrcA, ALUSrcB, ALUOp, trap}
  function automatic logic [16:0] outs_for(input logic [3:0] st, input bit rd, input logic [1:0] br);
    logic pcw, irw, rw, rdst, m2r, mr, mw, asa, tr;
    logic [1:0] pcs, brn, asb, aop;
    pcw = 0; irw = 0; rw = 0; rdst = 0; m2r = 0; mr = 0; mw = 0; asa = 0; tr = 0;
    pcs = 0; brn = 0; asb = 0; aop = 0;
    case (st)
      ST_FETCH:    begin irw = 1; pcw = 1; asb = 2'b01; end
      ST_DECODE:   asb = 2'b11;
      ST_EXEC_R:   begin asa = 1; aop = 2'b10; end
      ST_EXEC_I:   begin asa = 1; asb = 2'b10; end
      ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      ST_MEM_RD:   mr = 1;
      ST_MEM_WR:   mw = 1;
      ST_WB_ALU:   begin rw = 1; rdst = rd; end
      ST_WB_MEM:   begin rw = 1; m2r = 1; end
      ST_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 2'b01; brn = br; end
      ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
      ST_TRAP:     tr = 1;
      default:     ;
    endcase
    return {pcw, pcs, brn, irw, rw, rdst, m2r, mr, mw, asa, asb, aop, tr};
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom_range(63, 0));
  endfunction

  task automatic push(input bit rst, input bit chk, input logic [5:0] op, input bit rdy,
                      input logic [3:0] st, input bit rd, input logic [1:0] br);
    cyc_t e;
    e.rst = rst; e.chk = chk; e.op = op; e.rdy = rdy; e.st = st;
    e.outs = outs_for(st, rd, br); e.tag = cur_tag; e.ecyc = m_cyc; e.einst = m_inst;
    trace.push_back(e);
    if (rst) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      if (st != ST_IDLE && st != ST_TRAP) m_cyc = m_cyc + 1;
      if (st == ST_FETCH) m_inst = m_inst + 1;
    end
  endtask

  task automatic p(input logic [5:0] op, input bit rdy, input logic [3:0] st);
    push(1'b0, 1'b1, op, rdy, st, 1'b0, 2'b00);
  endtask

  // One instruction from FETCH; opcode is only meaningful in DECODE and MEM_ADDR, so junk elsewhere.
  task automatic instr(input int tag, input logic [5:0] op, input int waits);
    cur_tag = tag;
    p(junk(), 1'b1, ST_FETCH);
    p(op, 1'b1, ST_DECODE);
    case (op)
      OP_R: begin
        p(junk(), 1'b0, ST_EXEC_R);
        push(1'b0, 1'b1, junk(), 1'b0, ST_WB_ALU, 1'b1, 2'b00);
      end
      OP_ADDI: begin
        p(junk(), 1'b0, ST_EXEC_I);
        push(1'b0, 1'b1, junk(), 1'b1, ST_WB_ALU, 1'b0, 2'b00);
      end
      OP_LW, OP_SW: begin
        p(op, 1'b0, ST_MEM_ADDR);
        for (int i = 0; i < waits && i < TO; i++)
          p(junk(), 1'b0, (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR);
        if (waits >= TO) begin
          p(junk(), 1'b0, ST_TRAP);
        end else begin
          p(junk(), 1'b1, (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR);
          if (op == OP_LW) p(junk(), 1'b0, ST_WB_MEM);
        end
      end
      OP_BEQ: push(1'b0, 1'b1, junk(), 1'b0, ST_BRANCH, 1'b0, 2'b01);
      OP_BNE: push(1'b0, 1'b1, junk(), 1'b0, ST_BRANCH, 1'b0, 2'b10);
      OP_J:   p(junk(), 1'b0, ST_JUMP);
      default: p(junk(), 1'b0, ST_TRAP);
    endcase
  endtask

  task automatic reset_pulse(input int tag, input logic [3:0] prev_st, input int n);
    cur_tag = tag;
    push(1'b1, 1'b1, junk(), 1'b0, prev_st, 1'b0, 2'b00);
    for (int i = 1; i < n; i++) push(1'b1, 1'b1, junk(), 1'b0, ST_IDLE, 1'b0, 2'b00);
    p(junk(), 1'b0, ST_IDLE);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic build();
    cur_tag = 0;
    push(1'b1, 1'b0, 6'd0, 1'b0, ST_IDLE, 1'b0, 2'b00);
    push(1'b1, 1'b1, 6'd0, 1'b0, ST_IDLE, 1'b0, 2'b00);
    push(1'b1, 1'b1, 6'd0, 1'b0, ST_IDLE, 1'b0, 2'b00);
    p(6'd0, 1'b0, ST_IDLE);
    instr(1, OP_R, 0);
    instr(2, OP_ADDI, 0);
    instr(3, OP_LW, 3);
    instr(4, OP_SW, 0);
    instr(5, OP_BEQ, 0);
    instr(6, OP_BNE, 0);
    instr(7, OP_J, 0);
    instr(8, OP_LW, 0);
    // Reset lands in the middle of a read wait; MemRead must drop the next cycle.
    cur_tag = 9;
    p(junk(), 1'b1, ST_FETCH);
    p(OP_LW, 1'b1, ST_DECODE);
    p(OP_LW, 1'b0, ST_MEM_ADDR);
    p(junk(), 1'b0, ST_MEM_RD);
    reset_pulse(9, ST_MEM_RD, 1);
    instr(10, OP_SW, 2);
    instr(11, OP_BAD, 0);
    for (int i = 0; i < 19; i++) p(junk(), 1'b1, ST_TRAP);
    reset_pulse(11, ST_TRAP, 1);
    instr(12, OP_SW, TO);
    p(junk(), 1'b0, ST_TRAP);
    p(junk(), 1'b1, ST_TRAP);
    reset_pulse(13, ST_TRAP, 2);
  endtask

  initial begin
    logic [16:0] act;
    cyc_t e;
    n_total = 0; n_pass = 0; m_cyc = 0; m_inst = 0; cur_tag = 0; obs_ic = 0;
    for (int i = 0; i < 16; i++) begin
      obs_mr[i] = 0; obs_mw[i] = 0; obs_tr[i] = 0; obs_nf[i] = 0;
    end
    reset = 1'b1; bus_if.Opcode = 6'd0; bus_if.mem_ready = 1'b0;
    build();
    for (int i = 0; i < trace.size(); i++) begin
      e = trace[i];
      reset = e.rst; bus_if.Opcode = e.op; bus_if.mem_ready = e.rdy;
      act = {bus_if.PCWrite, bus_if.PCSrc, bus_if.Branch, bus_if.IRWrite, bus_if.RegWrite,
             bus_if.RegDst, bus_if.MemtoReg, bus_if.MemRead, bus_if.MemWrite, bus_if.ALUSrcA,
             bus_if.ALUSrcB, bus_if.ALUOp, bus_if.trap};
      if (e.chk) begin
        check("state", i, 32'(bus_if.state_out), 32'(e.st));
        check("ctrl", i, 32'(act), 32'(e.outs));
`ifdef CTRL_PERF_COUNTERS_EN
        check("cycle_count", i, cycle_count, e.ecyc);
        check("instr_count", i, instr_count, e.einst);
`endif
        if (!e.rst) begin
          if (bus_if.MemRead)  obs_mr[e.tag]++;
          if (bus_if.MemWrite) obs_mw[e.tag]++;
          if (bus_if.trap)     obs_tr[e.tag]++;
          if (bus_if.state_out != ST_FETCH) obs_nf[e.tag]++;
        end
`ifdef CTRL_PERF_COUNTERS_EN
        if (e.tag == 12) obs_ic = instr_count;
`endif
      end
      $display("step %0d tag %0d rst=%0b op=%b rdy=%0b state=%0d ctrl=%h",
               i, e.tag, e.rst, e.op, e.rdy, bus_if.state_out, act);
      @(posedge clk);
      #1;
    end
    check("r_type_cpi", -1, 32'(obs_nf[1] + 1), 32'd4);
    check("lw_memread_cycles", -1, 32'(obs_mr[3]), 32'd4);
    check("lw_wait_total_cycles", -1, 32'(obs_nf[3] + 1), 32'd8);
    check("sw_cpi", -1, 32'(obs_nf[4] + 1), 32'd4);
    check("bne_cpi", -1, 32'(obs_nf[6] + 1), 32'd3);
    check("j_cpi", -1, 32'(obs_nf[7] + 1), 32'd3);
    check("lw_zero_wait_cpi", -1, 32'(obs_nf[8] + 1), 32'd5);
    check("trap_cycles", -1, 32'(obs_tr[11]), 32'd20);
    check("sw_timeout_memwrite", -1, 32'(obs_mw[12]), 32'd15);
`ifdef CTRL_PERF_COUNTERS_EN
    check("instr_count_after_timeout", -1, obs_ic, 32'd1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
